// File: rtl/axi_wrr_arbiter.sv
// rtl/axi_wrr_arbiter.sv - weighted round-robin, transaction-locking AXI address channel arbiter
// Optional starvation guard: define AXI_WRR_ARBITER_STARVATION_EN.
module axi_wrr_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [MASTER_NUM-1:0]              request,
  input  logic [MASTER_NUM*WEIGHT_WIDTH-1:0] weight,
  input  logic                               done,
  output logic [MASTER_NUM-1:0]              grant,
  output logic [$clog2(MASTER_NUM)-1:0]      grant_bin,
  output logic                               locked
);

  localparam int IDX_W = $clog2(MASTER_NUM);
  localparam int RUN_W = WEIGHT_WIDTH + 1;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  state_e                  state_q, state_d;
  logic [MASTER_NUM-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]        grant_bin_q, grant_bin_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [RUN_W-1:0]        run_q, run_d;

  logic [WEIGHT_WIDTH-1:0] w_raw;
  logic [RUN_W-1:0]        w_last;
  logic                    scan_found;
  logic [IDX_W-1:0]        scan_idx;
  logic [IDX_W-1:0]        sel_idx;
  logic [RUN_W-1:0]        sel_run;

  // Rotation candidate: first requester after last, wrapping back to last itself
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = last_q;
    for (int k = 1; k <= MASTER_NUM; k++) begin
      if (!scan_found && request[(int'(last_q) + k) % MASTER_NUM]) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'((int'(last_q) + k) % MASTER_NUM);
      end
    end
  end

`ifdef AXI_WRR_ARBITER_STARVATION_EN
  localparam int                WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] wait_q [MASTER_NUM];
  logic [WAIT_W-1:0] wait_d [MASTER_NUM];
  logic              starve_any;
  logic [IDX_W-1:0]  starve_idx;

  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (wait_q[i] == WAIT_MAX) begin
        starve_any = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      wait_d[i] = wait_q[i];
      if (!request[i] || grant_q[i] || grant_d[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_MAX) begin
        wait_d[i] = wait_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (!rstn) begin
        wait_q[i] <= '0;
      end else begin
        wait_q[i] <= wait_d[i];
      end
    end
  end
`else
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  // run_q == 0 means nobody has been granted since reset, so no run continues
  always_comb begin
    w_raw   = weight[int'(last_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    w_last  = (w_raw == '0) ? RUN_W'(1) : {1'b0, w_raw};
    sel_idx = scan_idx;
    sel_run = RUN_W'(1);
    if (request[last_q] && (run_q != '0) && (run_q < w_last)) begin
      sel_idx = last_q;
      sel_run = run_q + RUN_W'(1);
    end
`ifdef AXI_WRR_ARBITER_STARVATION_EN
    if (starve_any) begin
      sel_idx = starve_idx;
      sel_run = RUN_W'(1);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_bin_d = grant_bin_q;
    last_d      = last_q;
    run_d       = run_q;
    case (state_q)
      ST_IDLE: begin
        if (request != '0) begin
          state_d     = ST_LOCKED;
          grant_d     = {{(MASTER_NUM-1){1'b0}}, 1'b1} << sel_idx;
          grant_bin_d = sel_idx;
          last_d      = sel_idx;
          run_d       = sel_run;
        end
      end
      ST_LOCKED: begin
        // Owner's valid may still be high now, so the bubble cycle follows done
        if (done) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          grant_bin_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        grant_bin_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_bin_q <= '0;
      last_q      <= IDX_W'(MASTER_NUM - 1);
      run_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_bin_q <= grant_bin_d;
      last_q      <= last_d;
      run_q       <= run_d;
    end
  end

  assign grant     = grant_q;
  assign grant_bin = grant_bin_q;
  assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axi_wrr_arbiter.sv
// tb/tb_axi_wrr_arbiter.sv - self-checking bench for axi_wrr_arbiter with a transaction-level reference model
module tb_axi_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  request;
  logic [N*WW-1:0] weight;
  logic          done;
  logic [N-1:0]  grant;
  logic [1:0]    grant_bin;
  logic          locked;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_locked;
  int m_owner;
  int m_last;
  int m_run;
  int m_wait [N];

  axi_wrr_arbiter #(
    .MASTER_NUM    (N),
    .WEIGHT_WIDTH  (WW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .request  (request),
    .weight   (weight),
    .done     (done),
    .grant    (grant),
    .grant_bin(grant_bin),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one clock using the current inputs, then compare.
  task automatic step(input string tag);
    bit         prev_locked;
    int         prev_owner;
    int         pick;
    int         w [N];
    logic [N-1:0] g_exp;
    logic [1:0]   b_exp;
    prev_locked = m_locked;
    prev_owner  = m_owner;
    pick        = -1;
    for (int i = 0; i < N; i++) begin
      w[i] = int'(weight[i*WW +: WW]);
      if (w[i] == 0) w[i] = 1;
    end
    if (!rstn) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_last   = N - 1;
      m_run    = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      if (m_locked) begin
        if (done) m_locked = 1'b0;
      end else if (request != '0) begin
`ifdef AXI_WRR_ARBITER_STARVATION_EN
        for (int i = 0; i < N; i++)
          if (pick < 0 && m_wait[i] == TO) pick = i;
`endif
        if (pick >= 0) begin
          m_run = 1;
        end else if (m_run > 0 && request[m_last] && m_run < w[m_last]) begin
          pick  = m_last;
          m_run = m_run + 1;
        end else begin
          for (int k = 1; k <= N; k++)
            if (pick < 0 && request[(m_last + k) % N]) pick = (m_last + k) % N;
          m_run = 1;
        end
        m_last   = pick;
        m_locked = 1'b1;
        m_owner  = pick;
      end
`ifdef AXI_WRR_ARBITER_STARVATION_EN
      for (int i = 0; i < N; i++) begin
        if (!request[i] || (prev_locked && prev_owner == i) || pick == i) m_wait[i] = 0;
        else if (m_wait[i] < TO) m_wait[i] = m_wait[i] + 1;
      end
`endif
    end
    g_exp = '0;
    b_exp = '0;
    if (m_locked) begin
      g_exp[m_owner] = 1'b1;
      b_exp = 2'(m_owner);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (grant !== g_exp || grant_bin !== b_exp || locked !== m_locked) begin
      n_fail++;
      $display("FAIL model_%s: grant=%b bin=%0d locked=%b, expected grant=%b bin=%0d locked=%b",
               tag, grant, grant_bin, locked, g_exp, b_exp, m_locked);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    done = 1'b0;
    step("reset");
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    request = 4'b1111;
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    done    = 1'b1;
    rstn    = 1'b0;
    step("reset_a");
    step("reset_b");
    n_checks++;
    if (grant !== 4'b0000 || grant_bin !== 2'd0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b bin=%0d locked=%b, expected 0000/0/0", grant, grant_bin, locked);
    end
    rstn    = 1'b1;
    done    = 1'b0;
    request = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    request = 4'b0001;
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    step("single_arb");
    n_checks++;
    if (grant !== 4'b0001 || grant_bin !== 2'd0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b bin=%0d locked=%b, expected 0001/0/1", grant, grant_bin, locked);
    end
    done = 1'b1;
    step("single_done");
    done = 1'b0;
    n_checks++;
    if (grant !== 4'b0000 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL single_bubble: grant=%b locked=%b, expected 0000/0", grant, locked);
    end
    step("single_regrant");
    n_checks++;
    if (grant !== 4'b0001 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_regrant: grant=%b locked=%b, expected 0001/1", grant, locked);
    end
    done = 1'b1;
    step("single_done2");
    done    = 1'b0;
    request = 4'b0000;
  endtask

  task automatic test_round_robin();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    request = 4'b1111;
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int t = 0; t < 5; t++) begin
      step("rr_arb");
      n_checks++;
      if (grant_bin !== 2'(exp_seq[t]) || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: bin=%0d locked=%b, expected bin=%0d locked=1", t, grant_bin, locked, exp_seq[t]);
      end
      done = 1'b1;
      step("rr_done");
      done = 1'b0;
      n_checks++;
      if (locked !== 1'b0 || grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_bubble[%0d]: grant=%b locked=%b, expected 0000/0", t, grant, locked);
      end
    end
    request = 4'b0000;
  endtask

  task automatic test_weighted();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    request = 4'b0011;
    weight  = {4'd1, 4'd1, 4'd1, 4'd3};
    for (int t = 0; t < 8; t++) begin
      step("wrr_arb");
      n_checks++;
      if (grant_bin !== 2'(exp_seq[t]) || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL wrr_seq[%0d]: bin=%0d locked=%b, expected bin=%0d locked=1", t, grant_bin, locked, exp_seq[t]);
      end
      done = 1'b1;
      step("wrr_done");
      done = 1'b0;
    end
    request = 4'b0000;
  endtask

  task automatic test_zero_weight_hold();
    do_reset();
    request = 4'b0100;
    weight  = {4'd1, 4'd0, 4'd1, 4'd1};
    for (int t = 0; t < 4; t++) begin
      step("zw_arb");
      n_checks++;
      if (grant !== 4'b0100 || grant_bin !== 2'd2) begin
        n_fail++;
        $display("FAIL zero_weight[%0d]: grant=%b bin=%0d, expected 0100/2", t, grant, grant_bin);
      end
      done = 1'b1;
      step("zw_done");
      done = 1'b0;
    end
    step("hold_arb");
    request = 4'b0000;
    for (int t = 0; t < 3; t++) begin
      step("hold");
      n_checks++;
      if (grant !== 4'b0100 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_after_drop[%0d]: grant=%b locked=%b, expected 0100/1", t, grant, locked);
      end
    end
    done = 1'b1;
    step("hold_done");
    done = 1'b0;
    step("hold_idle");
    n_checks++;
    if (grant !== 4'b0000 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_request: grant=%b locked=%b, expected 0000/0", grant, locked);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    request = 4'b0100;
    weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    step("rml_arb");
    rstn = 1'b0;
    step("rml_reset");
    n_checks++;
    if (grant !== 4'b0000 || locked !== 1'b0 || grant_bin !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_lock: grant=%b bin=%0d locked=%b, expected 0000/0/0", grant, grant_bin, locked);
    end
    rstn    = 1'b1;
    request = 4'b1111;
    step("rml_first");
    n_checks++;
    if (grant !== 4'b0001 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL first_after_reset: grant=%b locked=%b, expected 0001/1", grant, locked);
    end
    done = 1'b1;
    step("rml_done");
    done    = 1'b0;
    request = 4'b0000;
  endtask

`ifdef AXI_WRR_ARBITER_STARVATION_EN
  task automatic test_starvation();
    int  zero_grants;
    bit  got_one;
    do_reset();
    request     = 4'b0011;
    weight      = {4'd1, 4'd1, 4'd1, 4'd15};
    zero_grants = 0;
    got_one     = 1'b0;
    for (int t = 0; t < 20 && !got_one; t++) begin
      step("stv_arb");
      if (grant_bin == 2'd1) got_one = 1'b1;
      else zero_grants++;
      for (int c = 0; c < 4; c++) step("stv_busy");
      done = 1'b1;
      step("stv_done");
      done = 1'b0;
    end
    n_checks++;
    if (!got_one || zero_grants == 0 || zero_grants >= 15) begin
      n_fail++;
      $display("FAIL starvation: req1_granted=%0d after %0d grants to 0, expected granted before 15", got_one, zero_grants);
    end
    request = 4'b0000;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 600; t++) begin
      rstn    = ($urandom_range(0, 79) != 0);
      request = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) request = 4'b1111;
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom());
      done = ($urandom_range(0, 2) == 0);
      step("random");
    end
    rstn = 1'b1;
    done = 1'b0;
  endtask

  initial begin
    rstn    = 1'b0;
    request = '0;
    weight  = '0;
    done    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_weighted();
    test_zero_weight_hold();
    test_reset_mid_lock();
`ifdef AXI_WRR_ARBITER_STARVATION_EN
    test_starvation();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
